// File: rtl/sonic_vc_tx_width_adapter_p0.sv
// 128-bit to 64-bit Avalon-ST TX width adapter with a two-slot skid buffer,
// configurable inter-packet gap after every eop, and packet/error counters.
module sonic_vc_tx_width_adapter_p0 #(
    parameter int GAP_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             wrclock,
    input  logic             reset_n,
    output logic             avalonst_sink_ready,
    input  logic             avalonst_sink_valid,
    input  logic [127:0]     avalonst_sink_data,
    input  logic [1:0]       avalonst_sink_empty,
    input  logic             avalonst_sink_startofpacket,
    input  logic             avalonst_sink_endofpacket,
    input  logic             avalonst_sink_error,
    input  logic             avalonst_source_ready,
    output logic             avalonst_source_valid,
    output logic [63:0]      avalonst_source_data,
    output logic             avalonst_source_empty,
    output logic             avalonst_source_startofpacket,
    output logic             avalonst_source_endofpacket,
    output logic             avalonst_source_error,
    input  logic [GAP_W-1:0] cfg_ipg,
    output logic [CNT_W-1:0] tx_pkt_count,
    output logic [CNT_W-1:0] tx_err_count,
    output logic [1:0]       debug_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Slot layout: [132] error, [131] eop, [130] sop, [129:128] empty, [127:0] data.
    logic [132:0]     h_slot, s_slot, in_beat;
    logic             h_valid, s_valid, req_d1;
    logic [1:0]       live_q;
    logic [1:0]       state, next_state, after_state;
    logic [GAP_W-1:0] gap_cnt, next_gap, after_gap;
    logic             live, two_halves, last_half, out_fire, h_free;
    logic [1:0]       room_used;

    // Handshakes: sink side has ready latency 1 (a beat may appear only in the
    // cycle after sink_ready was high, and is always taken); source side has
    // ready latency 0 (a half transfers when source_valid && source_ready).
    assign in_beat = {avalonst_sink_error, avalonst_sink_endofpacket,
                      avalonst_sink_startofpacket, avalonst_sink_empty,
                      avalonst_sink_data};

    // live goes high two edges after reset release, keeping both sides quiet meanwhile.
    assign live      = live_q[1];
    assign room_used = {1'b0, h_valid} + {1'b0, s_valid} + {1'b0, req_d1};
    assign avalonst_sink_ready = live && (room_used < 2'd2);

    assign two_halves = !h_slot[131] || !h_slot[129];
    assign last_half  = (state == ST_LO) || ((state == ST_HI) && !two_halves);
    assign out_fire   = avalonst_source_valid && avalonst_source_ready;
    assign h_free     = out_fire && last_half;

    assign avalonst_source_valid = live && ((state == ST_HI) || (state == ST_LO));
    assign avalonst_source_data  = !avalonst_source_valid ? 64'd0 :
                                   (state == ST_HI) ? h_slot[127:64] : h_slot[63:0];
    assign avalonst_source_startofpacket = avalonst_source_valid && (state == ST_HI) && h_slot[130];
    assign avalonst_source_endofpacket   = avalonst_source_valid && last_half && h_slot[131];
    assign avalonst_source_empty         = avalonst_source_endofpacket && h_slot[128];
    assign avalonst_source_error         = avalonst_source_valid && h_slot[132];
    assign debug_state                   = state;

    always_comb begin
        after_state = ST_IDLE;
        after_gap   = '0;
        if (h_slot[131] && (cfg_ipg != '0)) begin
            after_state = ST_GAP;
            after_gap   = cfg_ipg;
        end else if (s_valid || avalonst_sink_valid) begin
            after_state = ST_HI;
        end

        next_state = state;
        next_gap   = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (h_valid || avalonst_sink_valid) next_state = ST_HI;
            end
            ST_HI: begin
                if (out_fire) begin
                    if (two_halves) begin
                        next_state = ST_LO;
                    end else begin
                        next_state = after_state;
                        next_gap   = after_gap;
                    end
                end
            end
            ST_LO: begin
                if (out_fire) begin
                    next_state = after_state;
                    next_gap   = after_gap;
                end
            end
            default: begin
                // A beat landing on the last gap cycle goes straight into H.
                if (gap_cnt <= GAP_W'(1)) begin
                    next_gap   = '0;
                    next_state = (h_valid || avalonst_sink_valid) ? ST_HI : ST_IDLE;
                end else begin
                    next_gap = gap_cnt - GAP_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge wrclock) begin
        if (!reset_n) begin
            h_slot       <= '0;
            s_slot       <= '0;
            h_valid      <= 1'b0;
            s_valid      <= 1'b0;
            req_d1       <= 1'b0;
            live_q       <= 2'b00;
            state        <= ST_IDLE;
            gap_cnt      <= '0;
            tx_pkt_count <= '0;
            tx_err_count <= '0;
        end else begin
            req_d1  <= avalonst_sink_ready;
            live_q  <= {live_q[0], 1'b1};
            state   <= next_state;
            gap_cnt <= next_gap;

            // S always holds the younger beat, so it refills H before a new arrival.
            if (h_free) begin
                if (s_valid) begin
                    h_slot <= s_slot;
                    if (avalonst_sink_valid) s_slot <= in_beat;
                    else                     s_valid <= 1'b0;
                end else if (avalonst_sink_valid) begin
                    h_slot <= in_beat;
                end else begin
                    h_valid <= 1'b0;
                end
            end else if (avalonst_sink_valid) begin
                if (!h_valid) begin
                    h_slot  <= in_beat;
                    h_valid <= 1'b1;
                end else begin
                    s_slot  <= in_beat;
                    s_valid <= 1'b1;
                end
            end

            if (h_free && h_slot[131]) begin
                tx_pkt_count <= tx_pkt_count + CNT_W'(1);
                if (h_slot[132]) tx_err_count <= tx_err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sonic_vc_tx_width_adapter_p0.sv
// Bench for the 128->64 TX width adapter: an upstream FIFO model feeds beats,
// and a queue of expected 64-bit halves built from the packet rules is compared.
module tb_sonic_vc_tx_width_adapter_p0;
    localparam int GAP_W = 4;
    localparam int CNT_W = 32;

    logic             wrclock = 1'b0;
    logic             reset_n = 1'b0;
    logic             avalonst_sink_ready;
    logic             avalonst_sink_valid = 1'b0;
    logic [127:0]     avalonst_sink_data = '0;
    logic [1:0]       avalonst_sink_empty = '0;
    logic             avalonst_sink_startofpacket = 1'b0;
    logic             avalonst_sink_endofpacket = 1'b0;
    logic             avalonst_sink_error = 1'b0;
    logic             avalonst_source_ready = 1'b0;
    logic             avalonst_source_valid;
    logic [63:0]      avalonst_source_data;
    logic             avalonst_source_empty;
    logic             avalonst_source_startofpacket;
    logic             avalonst_source_endofpacket;
    logic             avalonst_source_error;
    logic [GAP_W-1:0] cfg_ipg = '0;
    logic [CNT_W-1:0] tx_pkt_count;
    logic [CNT_W-1:0] tx_err_count;
    logic [1:0]       debug_state;

    always #5 wrclock = ~wrclock;

    sonic_vc_tx_width_adapter_p0 #(.GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .wrclock                       (wrclock),
        .reset_n                       (reset_n),
        .avalonst_sink_ready           (avalonst_sink_ready),
        .avalonst_sink_valid           (avalonst_sink_valid),
        .avalonst_sink_data            (avalonst_sink_data),
        .avalonst_sink_empty           (avalonst_sink_empty),
        .avalonst_sink_startofpacket   (avalonst_sink_startofpacket),
        .avalonst_sink_endofpacket     (avalonst_sink_endofpacket),
        .avalonst_sink_error           (avalonst_sink_error),
        .avalonst_source_ready         (avalonst_source_ready),
        .avalonst_source_valid         (avalonst_source_valid),
        .avalonst_source_data          (avalonst_source_data),
        .avalonst_source_empty         (avalonst_source_empty),
        .avalonst_source_startofpacket (avalonst_source_startofpacket),
        .avalonst_source_endofpacket   (avalonst_source_endofpacket),
        .avalonst_source_error         (avalonst_source_error),
        .cfg_ipg                       (cfg_ipg),
        .tx_pkt_count                  (tx_pkt_count),
        .tx_err_count                  (tx_err_count),
        .debug_state                   (debug_state)
    );

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   empty;
        logic         sop;
        logic         eop;
        logic         err;
    } beat_t;

    // Expected half: [68] last half of its beat, [67] sop, [66] eop, [65] err, [64] empty, [63:0] data.
    beat_t       src_q[$];
    logic [68:0] exp_q[$];
    int          sop_cyc[$];
    int          eop_cyc[$];

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  occ = 0;
    int  gap_left = 0;
    int  pkt_cnt = 0;
    int  err_cnt = 0;
    int  halves = 0;
    int  first_in_cyc = -1;
    int  rdy_pct = 100;
    logic prev_ready = 1'b0;
    logic drv_valid = 1'b0;
    logic prev_free = 1'b0;
    logic held_valid = 1'b0;
    logic [67:0] held_val = '0;
    logic ipg_rand = 1'b0;
    logic [GAP_W-1:0] ipg_cfg = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic add_pkt(input int nbeats, input logic err, input logic [1:0] emp);
        beat_t b;
        logic  one;
        for (int i = 0; i < nbeats; i++) begin
            b.data  = {$urandom, $urandom, $urandom, $urandom};
            b.sop   = (i == 0);
            b.eop   = (i == nbeats - 1);
            b.err   = err;
            b.empty = b.eop ? emp : 2'($urandom_range(0, 3));
            src_q.push_back(b);
            one = b.eop && b.empty[1];
            exp_q.push_back({one, b.sop, one, b.err, one & b.empty[0], b.data[127:64]});
            if (!one) exp_q.push_back({1'b1, 1'b0, b.eop, b.err, b.eop & b.empty[0], b.data[63:0]});
        end
    endtask

    task automatic tick();
        logic [67:0] pk;
        logic [68:0] e;
        beat_t       b;
        @(posedge wrclock);
        cyc++;
        if (!reset_n) begin
            occ = 0; prev_ready = 1'b0; drv_valid = 1'b0; prev_free = 1'b0;
            gap_left = 0; held_valid = 1'b0; pkt_cnt = 0; err_cnt = 0;
            exp_q.delete();
            src_q.delete();
        end else begin
            if (drv_valid) occ++;
            if (prev_free) occ--;
            prev_free = 1'b0;
        end
        #1;
        drv_valid = 1'b0;
        b = beat_t'({$urandom, $urandom, $urandom, $urandom, 5'($urandom)});
        if (reset_n && prev_ready && src_q.size() > 0) begin
            b = src_q.pop_front();
            drv_valid = 1'b1;
            if (first_in_cyc < 0) first_in_cyc = cyc;
        end
        avalonst_sink_valid         = drv_valid;
        avalonst_sink_data          = b.data;
        avalonst_sink_empty         = b.empty;
        avalonst_sink_startofpacket = b.sop;
        avalonst_sink_endofpacket   = b.eop;
        avalonst_sink_error         = b.err;
        avalonst_source_ready       = ($urandom_range(0, 99) < rdy_pct);
        cfg_ipg = ipg_rand ? GAP_W'($urandom_range(0, 3)) : ipg_cfg;
        #4;
        if (reset_n) begin
            if (avalonst_sink_ready) check("sink_ready_room", 128'((occ + int'(prev_ready)) < 2), 1);
            prev_ready = avalonst_sink_ready;
            pk = {avalonst_source_startofpacket, avalonst_source_endofpacket, avalonst_source_error,
                  avalonst_source_empty, avalonst_source_data};
            if (held_valid) check("stall_hold", {avalonst_source_valid, pk}, {1'b1, held_val});
            if (gap_left > 0) begin
                check("gap_idle", avalonst_source_valid, 0);
                gap_left--;
            end
            if (avalonst_source_valid && avalonst_source_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_half", avalonst_source_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("half", pk, e[67:0]);
                    prev_free = e[68];
                    halves++;
                    if (e[67]) sop_cyc.push_back(cyc);
                    if (e[66]) begin
                        eop_cyc.push_back(cyc);
                        pkt_cnt++;
                        if (e[65]) err_cnt++;
                        gap_left = int'(cfg_ipg);
                    end
                end
            end
            held_valid = avalonst_source_valid && !avalonst_source_ready;
            held_val   = pk;
        end
    endtask

    task automatic quiet_outputs(input string tag);
        check(tag, {avalonst_sink_ready, avalonst_source_valid, avalonst_source_startofpacket,
                    avalonst_source_endofpacket, avalonst_source_error, avalonst_source_empty,
                    avalonst_source_data}, 0);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        quiet_outputs("rst_outputs");
        check("rst_state", debug_state, 0);
        reset_n = 1'b1;
        tick();
        quiet_outputs("post_rst_outputs");
        check("post_rst_state", debug_state, 0);
        check("post_rst_pkt", tx_pkt_count, 0);
        check("post_rst_err", tx_err_count, 0);
    endtask

    task automatic start_test();
        sop_cyc.delete();
        eop_cyc.delete();
        first_in_cyc = -1;
        halves = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0 || gap_left > 0 || drv_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int n;
        do_reset(3);

        // Single two-beat packet, tail empty = 1.
        rdy_pct = 100; ipg_cfg = '0; ipg_rand = 1'b0;
        start_test();
        add_pkt(2, 1'b0, 2'd1);
        drain(100);
        check("single_halves", halves, 4);
        check("single_pkt_count", tx_pkt_count, 1);

        // Short tail then back-to-back packet, plus idle-to-output latency.
        start_test();
        add_pkt(1, 1'b0, 2'd2);
        add_pkt(1, 1'b0, 2'd0);
        drain(100);
        check("short_halves", halves, 3);
        if (sop_cyc.size() > 1 && eop_cyc.size() > 0) begin
            check("short_next_sop", sop_cyc[1] - eop_cyc[0], 1);
            check("idle_latency", sop_cyc[0] - first_in_cyc, 1);
        end else begin
            check("short_sops_seen", sop_cyc.size(), 2);
        end

        // Gap insertion with cfg_ipg = 3.
        start_test();
        ipg_cfg = 4'd3;
        add_pkt(2, 1'b0, 2'd0);
        add_pkt(2, 1'b0, 2'd0);
        drain(100);
        if (sop_cyc.size() > 1 && eop_cyc.size() > 0) check("gap_three", sop_cyc[1] - eop_cyc[0], 4);
        else check("gap_sops_seen", sop_cyc.size(), 2);
        ipg_cfg = '0;

        // Full-rate streaming of a long non-eop run.
        start_test();
        add_pkt(4, 1'b0, 2'd0);
        drain(100);
        if (sop_cyc.size() > 0 && eop_cyc.size() > 0) check("full_rate", eop_cyc[0] - sop_cyc[0], 7);
        else check("full_rate_seen", eop_cyc.size(), 1);
        check("cum_pkt_count", tx_pkt_count, pkt_cnt);

        // Error counting: errors on packets 2 and 4.
        do_reset(2);
        ipg_cfg = 4'd1;
        for (int p = 1; p <= 5; p++)
            add_pkt($urandom_range(1, 3), (p == 2) || (p == 4), 2'($urandom_range(0, 3)));
        drain(400);
        check("err_test_pkt", tx_pkt_count, 5);
        check("err_test_err", tx_err_count, 2);

        // Random backpressure with a continuous stream and random gaps.
        do_reset(2);
        rdy_pct = 60; ipg_rand = 1'b1;
        for (int p = 0; p < 60; p++)
            add_pkt($urandom_range(1, 4), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        drain(5000);
        check("bp_pkt_count", tx_pkt_count, pkt_cnt);
        check("bp_err_count", tx_err_count, err_cnt);
        check("bp_all_out", exp_q.size(), 0);
        rdy_pct = 100; ipg_rand = 1'b0; ipg_cfg = '0;

        // Reset while the LO half of a beat is on the output.
        start_test();
        add_pkt(3, 1'b0, 2'd0);
        n = 0;
        while (debug_state !== 2'd2 && n < 50) begin
            tick();
            n++;
        end
        check("midrst_reach_lo", debug_state, 2);
        reset_n = 1'b0;
        tick();
        check("midrst_state", debug_state, 0);
        quiet_outputs("midrst_outputs");
        check("midrst_pkt", tx_pkt_count, 0);
        check("midrst_err", tx_err_count, 0);
        tick();
        reset_n = 1'b1;
        tick();
        quiet_outputs("midrst_post_outputs");
        start_test();
        add_pkt(2, 1'b1, 2'd3);
        drain(100);
        check("midrst_clean_halves", halves, 3);
        check("midrst_clean_pkt", tx_pkt_count, 1);
        check("midrst_clean_err", tx_err_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sonic_vc_tx_width_adapter_p0.md
SONIC_VC_TX_WIDTH_ADAPTER_P0 -- requirements
Module: sonic_vc_tx_width_adapter_p0

Interface
REQ-001 SHALL have parameter GAP_W, default 4, meaning the width of cfg_ipg and of the gap counter.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the packet and error counters.
REQ-003 SHALL have ports as follows; there is one clock, and reset is synchronous and active-low:
- wrclock  in  1  clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- avalonst_sink_ready  out  1  request to the upstream TX FIFO; ready latency 1.
- avalonst_sink_valid  in  1  beat present; may be high only in the cycle after sink_ready was high.
- avalonst_sink_data  in  128  beat; bits 127:64 are sent first.
- avalonst_sink_empty  in  2  unused 32-bit words in an eop beat, counted from the low end.
- avalonst_sink_startofpacket, avalonst_sink_endofpacket, avalonst_sink_error  in  1 each  sop, eop and error flags.
- avalonst_source_ready  in  1  downstream accept; ready latency 0.
- avalonst_source_valid  out  1  output beat valid.
- avalonst_source_data  out  64  output beat.
- avalonst_source_empty  out  1  1 means bits 31:0 of an eop beat are unused.
- avalonst_source_startofpacket, avalonst_source_endofpacket, avalonst_source_error  out  1 each  sop, eop and error flags.
- cfg_ipg  in  GAP_W  number of idle cycles forced after each output eop; sampled at eop acceptance.
- tx_pkt_count  out  CNT_W  count of eop beats accepted at the output.
- tx_err_count  out  CNT_W  count of eop beats accepted at the output with error set.

Function
REQ-004 SHALL use two 133-bit storage slots: H (active) and S (skid), each with a valid flag, plus a registered req_d1 equal to the previous cycle's sink_ready.
REQ-005 SHALL drive sink_ready = (occupied slots + req_d1) < 2, and SHALL accept every sink_valid beat without loss.
REQ-006 SHALL load an arriving beat into H if H is empty or is being freed in the same cycle, otherwise into S; S SHALL move to H when H frees.
REQ-007 SHALL run a state machine with states IDLE, HI, LO and GAP:
- IDLE: H empty; source_valid = 0; go to HI once H is loaded.
- HI: source_data = H[127:64]; sop = H.sop.
- LO: source_data = H[63:0]; sop = 0.
- GAP: source_valid = 0; the gap counter decrements each cycle.
REQ-008 SHALL compute the number of 64-bit halves in a beat as follows: a non-eop beat, or an eop beat with empty 0 or 1, SHALL be two halves (HI then LO); an eop beat with empty 2 or 3 SHALL be HI only.
REQ-009 SHALL set source_endofpacket only on the final half of an eop beat, with source_empty = empty[0] on that half and 0 elsewhere.
REQ-010 SHALL drive source_error equal to H.error on every half of the beat.
REQ-011 SHALL advance from HI or LO only when source_valid and source_ready are both high, and SHALL hold data and flags stable otherwise.
REQ-012 SHALL, after the final half of a beat is accepted:
- with no eop: go to HI if a next beat is available, else IDLE;
- on eop with cfg_ipg = 0: same as the no-eop case;
- on eop with cfg_ipg = N > 0: go to GAP for exactly N cycles, then to HI or IDLE.
REQ-013 SHALL allow beats to arrive into the slots during GAP.
REQ-014 SHALL have a latency of 1 cycle from sink_valid to source_valid when in IDLE with the gap expired.
REQ-015 SHALL sustain one output half per cycle during back-to-back non-eop beats while source_ready is held high.
REQ-016 SHALL increment tx_pkt_count on each accepted output eop, and SHALL also increment tx_err_count when error is set; both counters SHALL wrap modulo 2^CNT_W.
REQ-017 SHALL pass sop and eop on the same input beat through unchanged, as a single-beat packet.

Reset
REQ-018 SHALL, while reset_n = 0 at a clock edge, clear H, S, req_d1 and both counters, load the gap counter with 0, and enter state IDLE.
REQ-019 SHALL hold sink_ready, source_valid, sop, eop, error and empty at 0, and source_data at 0, during reset and in the cycle after reset.
REQ-020 SHALL abandon any partial packet on reset mid-packet without emitting eop; the upstream FIFO is reset together with this block.

Verification
REQ-021 SHALL be tested with a single packet: two beats, second beat eop with empty = 1, source_ready held at 1 -> four halves with eop on the fourth half, source_empty = 1, tx_pkt_count = 1.
REQ-022 SHALL be tested with a short tail: eop beat with empty = 2 -> one half only, source_empty = 0, and the next packet's sop follows on the next cycle when cfg_ipg = 0.
REQ-023 SHALL be tested for gap insertion: cfg_ipg = 3 with two back-to-back packets -> exactly 3 cycles with source_valid = 0 between the first eop and the next sop.
REQ-024 SHALL be tested for backpressure: source_ready toggled randomly with a continuous input stream -> no beat lost or duplicated, data stable while stalled, and sink_ready never high while both slots are occupied.
REQ-025 SHALL be tested for error counting: 5 packets with the error flag set on packets 2 and 4 -> tx_pkt_count = 5 and tx_err_count = 2.
REQ-026 SHALL be tested with reset mid-packet: reset asserted in state LO -> the next cycle shows state IDLE, all outputs 0 and counters 0, and a following packet passes cleanly.
